i3c_controller: RTL and testbench
=================================

I3C_CONTROLLER -- requirements
Module: i3c_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, target address width.
REQ-002 Parameter DATA_WIDTH, default 8, data byte width.
REQ-003 Parameter STATE_WIDTH, default 3, state code width.
REQ-004 Parameter HALF_PERIOD, default 4, clk_i cycles per SCL half-period (minimum 2).
REQ-005 The block SHALL have one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-006 Ports (name, direction, width, meaning):
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- scl_i  in  1  SCL bus level (monitor only).
- sda_i  in  1  SDA bus level.
- scl_o  out  1  SCL drive: 0 in low half, 1 in high half and idle.
- sda_o  out  1  SDA open-drain: 1'b0 or 1'bz only.
- sel_od_pp_o  out  1  1 = push-pull during write-data bits; 0 = open-drain otherwise.
- device_address  in  ADDR_WIDTH  target address.
- start_transfer  in  1  request; sampled only in IDLE.
- is_read  in  1  1 = read, 0 = write.
- write_data  in  DATA_WIDTH  write byte.
- read_data  out  DATA_WIDTH  last received byte.
- transfer_complete  out  1  one-cycle done pulse.
- error  out  1  one-cycle address-NACK pulse.
- current_state_o  out  STATE_WIDTH  registered FSM state.

Function
REQ-007 The state codes SHALL be IDLE=0, START=1, ADDRESS=2, DATA=3, STOP=4, ERROR=5.
REQ-008 In IDLE with start_transfer=1, the block SHALL latch device_address, is_read and write_data and enter START on the next edge; start_transfer is ignored in other states.
REQ-009 START: with SCL high, sda_o SHALL go 0 and be held HALF_PERIOD cycles, then SCL goes low and the state goes to ADDRESS.
REQ-010 Bit timing:
- Each bit SHALL be SCL low for HALF_PERIOD cycles, then SCL high for HALF_PERIOD cycles.
- SDA SHALL change only while SCL is low.
- sda_i SHALL be sampled on the cycle SCL goes high.
- A sample is bit 0 if sda_i==0, otherwise 1 (Z counts as 1).
REQ-011 ADDRESS:
- The block SHALL send the 7 address bits MSB first, then the R/W bit (1 = read).
- sda_o drives 0 for a 0 bit and Z for a 1 bit.
- On the 9th bit it releases SDA and samples ACK (ACK = 0).
REQ-012 After ADDRESS, ACK SHALL lead to DATA and NACK SHALL lead to ERROR.
REQ-013 DATA write:
- The block SHALL send write_data MSB first, with sel_od_pp_o=1 during these 8 bits.
- It then clocks a 9th bit with SDA released; the sampled value is ignored.
- The state then goes to STOP.
REQ-014 DATA read:
- The block SHALL release SDA and shift 8 samples MSB first.
- It then clocks a 9th bit with SDA released.
- The state then goes to STOP.
REQ-015 STOP:
- The block SHALL hold SCL low with SDA driven 0 for HALF_PERIOD cycles.
- It then holds SCL high for HALF_PERIOD cycles.
- It then releases SDA, which is the stop condition, and enters IDLE.
REQ-016 On entry to IDLE from a successful STOP, transfer_complete SHALL pulse for one cycle.
- On a read, read_data SHALL update in the same cycle; on a write, read_data is unchanged.
REQ-017 ERROR SHALL last one cycle with error=1, then enter STOP; the following STOP SHALL NOT assert transfer_complete.
REQ-018 current_state_o SHALL equal the registered state every cycle.
REQ-019 In IDLE, scl_o SHALL be 1, sda_o Z and sel_od_pp_o 0.

Reset
REQ-020 On rst_i=1 at a clk_i edge, the block SHALL set:
- state to IDLE, scl_o=1, sda_o=Z, sel_od_pp_o=0;
- read_data=0, transfer_complete=0, error=0;
- all latches and counters to 0.
This applies from any state, including mid-transfer, with no STOP generated.

Verification
REQ-021 Write 0x50 / 0xA5 with target ACK on address:
- Address bits 1010000 then R/W=0 appear on SDA.
- The data bits 10100101 appear on SDA.
- The states run START, ADDRESS, DATA, STOP, IDLE.
- transfer_complete pulses once.
REQ-022 Read 0x51 with ACK, target drives 0x3C (00111100) changing on SCL falling edges:
- read_data==0x3C when transfer_complete pulses.
- R/W bit sent as 1.
REQ-023 Address NACK (SDA left released):
- ADDRESS leads to ERROR; error pulses one cycle.
- STOP is generated, then IDLE; transfer_complete never asserts.
REQ-024 start_transfer pulsed during DATA: ignored; the current transfer completes unchanged.
REQ-025 rst_i asserted mid-ADDRESS: next cycle state=IDLE, scl_o=1, sda_o=Z, and no transfer_complete pulse.
REQ-026 Timing check: every SDA transition other than START and STOP occurs while SCL=0, and each SCL half lasts exactly HALF_PERIOD cycles.

Source files
------------

// File: rtl/i3c_controller.sv
// Single-target I3C/I2C-style controller: START, address + R/W, one data byte, STOP.
// SCL and SDA come straight from registers, so each bus edge lines up with a clk_i edge.
module i3c_controller #(
   parameter int ADDR_WIDTH  = 7,
   parameter int DATA_WIDTH  = 8,
   parameter int STATE_WIDTH = 3,
   parameter int HALF_PERIOD = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   scl_i,
   input  logic                   sda_i,
   output logic                   scl_o,
   output logic                   sda_o,
   output logic                   sel_od_pp_o,
   input  logic [ADDR_WIDTH-1:0]  device_address,
   input  logic                   start_transfer,
   input  logic                   is_read,
   input  logic [DATA_WIDTH-1:0]  write_data,
   output logic [DATA_WIDTH-1:0]  read_data,
   output logic                   transfer_complete,
   output logic                   error,
   output logic [STATE_WIDTH-1:0] current_state_o
);
   localparam int CW = $clog2(HALF_PERIOD) + 1;
   localparam int BW = $clog2(ADDR_WIDTH + DATA_WIDTH + 2);
   localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_PERIOD - 1);
   localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_WIDTH + 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH);

   typedef enum logic [STATE_WIDTH-1:0] {
      IDLE = 0, START = 1, ADDRESS = 2, DATA = 3, STOP = 4, ERROR = 5
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d, nxt_bit;
   logic                  hi_q, hi_d, scl_q, scl_d, sda_low_q, sda_low_d, pp_q, pp_d;
   logic                  rd_q, rd_d, samp_q, samp_d, fail_q, fail_d;
   logic                  done_q, done_d, err_q, err_d, rx_bit, last_bit;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, shift_q, shift_d, rdata_q, rdata_d;
   logic [ADDR_WIDTH+1:0] aframe, ash;
   logic [DATA_WIDTH:0]   dframe, dsh;
   logic                  unused_scl;

   // Trailing 1 in each frame is the released ninth bit.
   assign aframe  = {addr_q, rd_q, 1'b1};
   assign dframe  = rd_q ? '1 : {wdata_q, 1'b1};
   assign nxt_bit = bit_q + 1'b1;
   assign ash     = aframe << nxt_bit;
   assign dsh     = dframe << nxt_bit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;   cnt_q <= '0;     bit_q <= '0;     hi_q <= 1'b0;
         scl_q <= 1'b1;     sda_low_q <= 1'b0; pp_q <= 1'b0;  rd_q <= 1'b0;
         samp_q <= 1'b0;    fail_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
         addr_q <= '0;      wdata_q <= '0;   shift_q <= '0;   rdata_q <= '0;
      end else begin
         state_q <= state_d; cnt_q <= cnt_d;  bit_q <= bit_d;  hi_q <= hi_d;
         scl_q <= scl_d;    sda_low_q <= sda_low_d; pp_q <= pp_d; rd_q <= rd_d;
         samp_q <= samp_d;  fail_q <= fail_d; done_q <= done_d; err_q <= err_d;
         addr_q <= addr_d;  wdata_q <= wdata_d; shift_q <= shift_d; rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;  cnt_d = cnt_q;    bit_d = bit_q;    hi_d = hi_q;
      scl_d = scl_q;      sda_low_d = sda_low_q; pp_d = pp_q; rd_d = rd_q;
      samp_d = samp_q;    fail_d = fail_q;  addr_d = addr_q;  wdata_d = wdata_q;
      shift_d = shift_q;  rdata_d = rdata_q;
      done_d = 1'b0;      err_d = 1'b0;
      rx_bit = 1'b1;
      if (sda_i == 1'b0) rx_bit = 1'b0;
      last_bit = (state_q == ADDRESS) ? (bit_q == ADDR_LAST) : (bit_q == DATA_LAST);
      case (state_q)
         IDLE: begin
            scl_d = 1'b1; sda_low_d = 1'b0; pp_d = 1'b0;
            if (start_transfer) begin
               addr_d = device_address; rd_d = is_read; wdata_d = write_data;
               shift_d = '0; bit_d = '0; cnt_d = '0; hi_d = 1'b0; fail_d = 1'b0;
               sda_low_d = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ADDRESS; cnt_d = '0; hi_d = 1'b0; bit_d = '0;
               scl_d = 1'b0; sda_low_d = ~aframe[ADDR_WIDTH+1];
            end else cnt_d = cnt_q + 1'b1;
         end
         ADDRESS, DATA: begin
            if (!hi_q) begin
               if (cnt_q == CNT_LAST) begin
                  hi_d = 1'b1; scl_d = 1'b1; cnt_d = '0;
               end else cnt_d = cnt_q + 1'b1;
            end else begin
               if (cnt_q == '0) begin
                  samp_d = rx_bit;
                  if (state_q == DATA && rd_q && bit_q < DATA_LAST)
                     shift_d = {shift_q[DATA_WIDTH-2:0], rx_bit};
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0; hi_d = 1'b0; scl_d = 1'b0;
                  if (!last_bit) begin
                     bit_d = nxt_bit;
                     sda_low_d = (state_q == ADDRESS) ? ~ash[ADDR_WIDTH+1] : ~dsh[DATA_WIDTH];
                     pp_d = (state_q == DATA) && !rd_q && (nxt_bit < DATA_LAST);
                  end else if (state_q == DATA) begin
                     state_d = STOP; sda_low_d = 1'b1; pp_d = 1'b0;
                  end else if (!samp_q) begin
                     state_d = DATA; bit_d = '0;
                     sda_low_d = ~dframe[DATA_WIDTH]; pp_d = ~rd_q;
                  end else begin
                     state_d = ERROR; err_d = 1'b1; fail_d = 1'b1;
                     sda_low_d = 1'b0; pp_d = 1'b0;
                  end
               end else cnt_d = cnt_q + 1'b1;
            end
         end
         ERROR: begin
            // The ERROR cycle counts as the first cycle of the STOP low half.
            state_d = STOP; cnt_d = CW'(1); hi_d = 1'b0; scl_d = 1'b0; sda_low_d = 1'b1;
         end
         STOP: begin
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
            else if (!hi_q) begin
               hi_d = 1'b1; scl_d = 1'b1; cnt_d = '0;
            end else begin
               state_d = IDLE; sda_low_d = 1'b0; cnt_d = '0; hi_d = 1'b0;
               done_d = ~fail_q; fail_d = 1'b0;
               if (rd_q && !fail_q) rdata_d = shift_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign unused_scl        = scl_i;
   assign scl_o             = scl_q;
   assign sda_o             = sda_low_q ? 1'b0 : 1'bz;
   assign sel_od_pp_o       = pp_q;
   assign read_data         = rdata_q;
   assign transfer_complete = done_q;
   assign error             = err_q;
   assign current_state_o   = state_q;
endmodule

// File: tb/tb_i3c_controller.sv
// Bench for i3c_controller: a bus-level target model plus expected bit streams built
// from the transfer parameters, compared against what appears on SCL/SDA.
module tb_i3c_controller;
   localparam int HP = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_i, start_transfer, is_read, tgt_low, sda_i, scl_i;
   logic [6:0] device_address;
   logic [7:0] write_data;
   wire        scl_o, sel_od_pp_o, transfer_complete, error;
   wire  [7:0] read_data;
   wire  [2:0] current_state_o;
   wire        sda_line;
   pullup (sda_line);

   assign sda_i = ((sda_line === 1'b0) || tgt_low) ? 1'b0 : 1'b1;
   assign scl_i = scl_o;

   i3c_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .STATE_WIDTH(3), .HALF_PERIOD(HP)) dut (
      .clk_i(clk), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o),
      .sda_o(sda_line), .sel_od_pp_o(sel_od_pp_o), .device_address(device_address),
      .start_transfer(start_transfer), .is_read(is_read), .write_data(write_data),
      .read_data(read_data), .transfer_complete(transfer_complete), .error(error),
      .current_state_o(current_state_o)
   );

   int vectors = 0, miscompares = 0;
   logic [7:0]  exp_rdata = 8'h00;
   logic [17:0] obs_bits;
   logic [23:0] obs_seq;
   logic [7:0]  obs_rdata_tc;
   logic        obs_timeout;
   int obs_nbits, obs_tc, obs_err, obs_pp, obs_tim, obs_hichg, obs_bad;

   // One transfer, recording what the bus shows; the target ACKs the address if ack=1
   // and, on reads, drives rb MSB first, changing only after SCL falls.
   task automatic run_xfer(input logic [6:0] a, input logic rd, input logic [7:0] wd,
                           input logic ack, input logic [7:0] rb, input logic inject);
      logic pscl, plow, scl_now, low_now, left, injected;
      logic [2:0] pst;
      int run, falls, post, k;
      obs_bits = '0; obs_seq = '0; obs_rdata_tc = '0; obs_timeout = 1'b0;
      obs_nbits = 0; obs_tc = 0; obs_err = 0; obs_pp = 0; obs_tim = 0; obs_hichg = 0; obs_bad = 0;
      tgt_low = 1'b0;
      @(negedge clk);
      device_address = a; is_read = rd; write_data = wd; start_transfer = 1'b1;
      pscl = scl_o; plow = (sda_line === 1'b0); pst = current_state_o;
      run = 1; falls = 0; post = 0; left = 1'b0; injected = 1'b0;
      for (int cyc = 0; cyc < 3000 && post < 4; cyc++) begin
         @(negedge clk);
         start_transfer = 1'b0;
         if (inject && !injected && current_state_o == 3'd3) begin
            injected = 1'b1; start_transfer = 1'b1;
            device_address = ~a; is_read = ~rd; write_data = ~wd;
         end
         scl_now = scl_o; low_now = (sda_line === 1'b0);
         if (current_state_o != pst) obs_seq = {obs_seq[19:0], 1'b0, current_state_o};
         if (scl_now != pscl) begin
            if (!pscl && run != HP) obs_tim++;
            if (pscl && falls > 0 && run != HP) obs_tim++;
            if (!scl_now) falls++;
            else if (current_state_o == 3'd2 || current_state_o == 3'd3) begin
               obs_bits = {obs_bits[16:0], sda_i}; obs_nbits++;
            end
            run = 1;
         end else run++;
         if (low_now != plow && scl_now && pscl) obs_hichg++;
         k = falls - 1;
         tgt_low = 1'b0;
         if (ack && k == 8) tgt_low = 1'b1;
         else if (ack && rd && k >= 9 && k <= 16) tgt_low = ~rb[16-k];
         if (sel_od_pp_o) begin obs_pp++; if (current_state_o != 3'd3) obs_bad++; end
         if (error) begin obs_err++; if (current_state_o != 3'd5) obs_bad++; end
         if (transfer_complete) begin
            obs_tc++; obs_rdata_tc = read_data;
            if (current_state_o != 3'd0) obs_bad++;
         end
         if (sda_line !== 1'b0 && sda_line !== 1'b1) obs_bad++;
         if (current_state_o != 3'd0) left = 1'b1;
         else if (left) post++;
         pscl = scl_now; plow = low_now; pst = current_state_o;
      end
      if (post < 4) obs_timeout = 1'b1;
      tgt_low = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_transfer = 1'b0; is_read = 1'b0; tgt_low = 1'b0;
      device_address = '0; write_data = '0;
      repeat (3) @(negedge clk);
      vectors++; if (current_state_o !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", current_state_o); end
      vectors++; if (scl_o !== 1'b1) begin miscompares++; $display("FAIL reset_scl: got %b want 1", scl_o); end
      vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b want released", sda_line); end
      vectors++; if (sel_od_pp_o !== 1'b0) begin miscompares++; $display("FAIL reset_pp: got %b want 0", sel_od_pp_o); end
      vectors++; if (read_data !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", read_data); end
      vectors++; if (transfer_complete !== 1'b0 || error !== 1'b0) begin
         miscompares++; $display("FAIL reset_pulses: got tc=%b err=%b want 0 0", transfer_complete, error); end
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_transfers(input int n);
      logic [6:0] a; logic rd, ack; logic [7:0] wd, rb;
      logic [17:0] eb; int en, epp;
      for (int i = 0; i < n; i++) begin
         case (i)
            0: begin a = 7'h50; rd = 1'b0; wd = 8'hA5; ack = 1'b1; rb = 8'h00; end
            1: begin a = 7'h51; rd = 1'b1; wd = 8'h00; ack = 1'b1; rb = 8'h3C; end
            2: begin a = 7'h2A; rd = 1'b0; wd = 8'h5A; ack = 1'b0; rb = 8'h00; end
            default: begin
               a = 7'($urandom); rd = 1'($urandom); wd = 8'($urandom);
               ack = ($urandom_range(0, 3) != 0); rb = 8'($urandom);
            end
         endcase
         run_xfer(a, rd, wd, ack, rb, 1'b0);
         eb = {9'd0, a, rd, ~ack}; en = 9;
         if (ack) begin eb = {eb[8:0], (rd ? rb : wd), 1'b1}; en = 18; end
         if (rd && ack) exp_rdata = rb;
         epp = (ack && !rd) ? 16 * HP : 0;
         vectors++; if (obs_timeout !== 1'b0) begin miscompares++; $display("FAIL xfer%0d_timeout: transfer did not return to IDLE", i); end
         vectors++; if (obs_nbits != en || obs_bits !== eb) begin
            miscompares++; $display("FAIL xfer%0d_bits: got %0d bits %h want %0d bits %h", i, obs_nbits, obs_bits, en, eb); end
         vectors++; if (obs_seq !== (ack ? 24'h012340 : 24'h012540)) begin
            miscompares++; $display("FAIL xfer%0d_states: got %h want %h", i, obs_seq, ack ? 24'h012340 : 24'h012540); end
         vectors++; if (obs_tc != int'(ack)) begin miscompares++; $display("FAIL xfer%0d_tc: got %0d pulses want %0d", i, obs_tc, ack); end
         vectors++; if (obs_err != int'(!ack)) begin miscompares++; $display("FAIL xfer%0d_err: got %0d cycles want %0d", i, obs_err, !ack); end
         if (ack) begin
            vectors++; if (obs_rdata_tc !== exp_rdata) begin
               miscompares++; $display("FAIL xfer%0d_rdata_at_tc: got %h want %h", i, obs_rdata_tc, exp_rdata); end
         end
         vectors++; if (read_data !== exp_rdata) begin miscompares++; $display("FAIL xfer%0d_rdata: got %h want %h", i, read_data, exp_rdata); end
         vectors++; if (obs_pp != epp) begin miscompares++; $display("FAIL xfer%0d_pp: got %0d cycles want %0d", i, obs_pp, epp); end
         vectors++; if (obs_tim != 0 || obs_hichg != 2) begin
            miscompares++; $display("FAIL xfer%0d_timing: got %0d bad halves, %0d sda-while-scl-high want 0, 2", i, obs_tim, obs_hichg); end
         vectors++; if (obs_bad != 0) begin miscompares++; $display("FAIL xfer%0d_misc: got %0d bad cycles want 0", i, obs_bad); end
      end
   endtask

   task automatic test_start_ignored();
      run_xfer(7'h33, 1'b0, 8'h96, 1'b1, 8'h00, 1'b1);
      vectors++; if (obs_bits !== {7'h33, 1'b0, 1'b0, 8'h96, 1'b1} || obs_nbits != 18) begin
         miscompares++; $display("FAIL inject_bits: got %0d bits %h want 18 bits %h", obs_nbits, obs_bits, {7'h33, 2'b00, 8'h96, 1'b1}); end
      vectors++; if (obs_seq !== 24'h012340) begin miscompares++; $display("FAIL inject_states: got %h want 012340", obs_seq); end
      vectors++; if (obs_tc != 1 || obs_pp != 16 * HP) begin
         miscompares++; $display("FAIL inject_done: got tc=%0d pp=%0d want 1 %0d", obs_tc, obs_pp, 16 * HP); end
      vectors++; if (read_data !== exp_rdata) begin miscompares++; $display("FAIL inject_rdata: got %h want %h", read_data, exp_rdata); end
   endtask

   task automatic test_reset_mid();
      int wait_cyc, tc_seen;
      @(negedge clk);
      device_address = 7'h6B; is_read = 1'b1; write_data = 8'h00; start_transfer = 1'b1;
      @(negedge clk);
      start_transfer = 1'b0;
      wait_cyc = 0;
      while (current_state_o != 3'd2 && wait_cyc < 300) begin @(negedge clk); wait_cyc++; end
      vectors++; if (current_state_o !== 3'd2) begin miscompares++; $display("FAIL rstmid_reach: got state %0d want 2", current_state_o); end
      repeat (5) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      exp_rdata = 8'h00;
      vectors++; if (current_state_o !== 3'd0) begin miscompares++; $display("FAIL rstmid_state: got %0d want 0", current_state_o); end
      vectors++; if (scl_o !== 1'b1 || sda_line !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_bus: got scl=%b sda=%b want 1 released", scl_o, sda_line); end
      vectors++; if (read_data !== exp_rdata || sel_od_pp_o !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_regs: got rdata=%h pp=%b want 00 0", read_data, sel_od_pp_o); end
      rst_i = 1'b0;
      tc_seen = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (transfer_complete || error || current_state_o != 3'd0) tc_seen++;
      end
      vectors++; if (tc_seen != 0) begin miscompares++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", tc_seen); end
   endtask

   initial begin
      test_reset();
      test_transfers(24);
      test_start_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
